tl_inflight_monitor: RTL and testbench
======================================

Name: tl_inflight_monitor

Overview:
- Sequential protocol checker for one TileLink-UL A/D channel pair.
- Tracks outstanding requests per source ID and beat progress of bursts.
- Drives active-high "ok" terms into the downstream single-cycle assert blocks, which print and fatal when every term of an OR group is low.
- Also keeps a sticky error flag and an in-flight counter for debug visibility.

Parameters:
- SOURCE_BITS, 4, width of a_source/d_source; tracks 2^SOURCE_BITS IDs.
- BEAT_BYTES, 8, data bus bytes per beat; power of two.
- MAX_SIZE, 6, largest legal log2 transfer size.

Ports:
- clock  in  1  sole clock.
- reset  in  1  asynchronous, active-high reset.
- a_valid  in  1  A channel valid.
- a_ready  in  1  A channel ready.
- a_opcode  in  3  A opcode: 0 PutFull, 1 PutPartial, 4 Get; others illegal.
- a_source  in  SOURCE_BITS  A source ID.
- a_size  in  4  A log2 size.
- d_valid  in  1  D channel valid.
- d_ready  in  1  D channel ready.
- d_opcode  in  3  D opcode: 0 AccessAck, 1 AccessAckData.
- d_source  in  SOURCE_BITS  D source ID.
- d_size  in  4  D log2 size.
- a_ok  out  1  low when an A-side violation occurs this cycle.
- d_ok  out  1  low when a D-side violation occurs this cycle.
- stable_ok  out  1  low when a stalled A or D beat changed its fields.
- error_sticky  out  1  set on the first violation; cleared only by reset.
- inflight_cnt  out  SOURCE_BITS+1  number of sources currently outstanding.

Behaviour:
- Reset values: inflight vector=0, beat counters=0, stall registers invalid, error_sticky=0, inflight_cnt=0.
- ok outputs are combinational from current inputs and state, so each check is sampled at the same posedge as the fire. All ok outputs are 1 whenever the corresponding valid is low.
- beats(op, size) = 1 for Put-with-no-data-response and for AccessAck. Otherwise it is max(1, 2^size/BEAT_BYTES).
- A-side data beats: PutFull and PutPartial carry beats(size). Get carries 1 beat.
- A fire is a_valid&a_ready. On the first beat (a_cnt==0):
  - a_ok=0 if inflight[a_source] is already set, a_opcode is illegal, or a_size>MAX_SIZE.
  - Otherwise record per source: expected D opcode (Put→0, Get→1) and size.
  - Set inflight[a_source] on the last A beat.
- a_cnt counts A beats and returns to 0 after the last beat.
- Mid A burst, a_ok=0 if a_source, a_opcode or a_size differ from the first beat.
- D fire is d_valid&d_ready. On the first beat (d_cnt==0), d_ok=0 if any of:
  - inflight[d_source] is clear;
  - d_opcode differs from the recorded value;
  - d_size differs from the recorded value.
- d_cnt counts D beats to beats(d_opcode, d_size). Mid burst, d_ok=0 if the source, opcode or size change.
- inflight[d_source] clears on the last D beat.
- Stall stability: a beat valid&!ready registers its fields. If valid is high next cycle, stable_ok=0 when any field differs. Dropping valid before ready is not checked.
- Simultaneous last-D retire and first-A allocate of the same source in one cycle is legal: the clear is applied before the A check (bypass), and the source ends the cycle set.
- inflight_cnt is updated +1, −1 or unchanged for simultaneous set and clear in one cycle. It never wraps, since the maximum is 2^SOURCE_BITS.
- error_sticky sets the cycle after any ok output is 0.
- A reset mid-burst clears all state immediately. A D beat arriving after reset is flagged as unknown source.

Test Plan:
1. Get src 3, size 6, BEAT_BYTES 8 → 8 AccessAckData beats, size 6. All oks stay 1, inflight_cnt goes 1→0 after the 8th beat.
2. PutFull src 2, size 3 → one AccessAck. Then a second A with src 2 while the first is still outstanding → a_ok=0 on that fire, error_sticky=1 on the next cycle.
3. D AccessAckData src 5 with nothing outstanding → d_ok=0. A Get src 1 answered by AccessAck → d_ok=0 (opcode mismatch).
4. A valid stalled 3 cycles with a_source changing 4→6 in the 2nd cycle → stable_ok=0 in that cycle only.
5. Same cycle: last D beat of src 7 and new Get on src 7 → a_ok=1, inflight[7]=1, inflight_cnt unchanged.
6. Reset asserted during beat 4 of an 8-beat D burst → all outputs at reset values. Remaining D beats → d_ok=0.

Source files
------------

// File: rtl/tl_inflight_monitor.sv
// tl_inflight_monitor
//
// Protocol checker for one TileLink-UL A/D channel pair. It tracks which
// source IDs have a request outstanding and how far each A and D burst has
// progressed. It drives active-high "ok" terms into downstream single-cycle
// assert blocks. Every ok term is combinational from the current inputs and
// the current state, so a check lands on the same clock edge as the fire it
// qualifies.
//
// Ports
//   clock, reset       sole clock; asynchronous active-high reset
//   a_valid/a_ready    A channel handshake
//   a_opcode           0 PutFull, 1 PutPartial, 4 Get (anything else illegal)
//   a_source, a_size   A source ID and log2 transfer size
//   d_valid/d_ready    D channel handshake
//   d_opcode           0 AccessAck, 1 AccessAckData
//   d_source, d_size   D source ID and log2 transfer size
//   a_ok               low on an A-side violation this cycle
//   d_ok               low on a D-side violation this cycle
//   stable_ok          low when a stalled A or D beat changed its fields
//   error_sticky       set the cycle after any ok term is low; reset clears it
//   inflight_cnt       number of source IDs currently outstanding
module tl_inflight_monitor #(
    parameter int SOURCE_BITS = 4,
    parameter int BEAT_BYTES  = 8,
    parameter int MAX_SIZE    = 6
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   a_valid,
    input  logic                   a_ready,
    input  logic [2:0]             a_opcode,
    input  logic [SOURCE_BITS-1:0] a_source,
    input  logic [3:0]             a_size,
    input  logic                   d_valid,
    input  logic                   d_ready,
    input  logic [2:0]             d_opcode,
    input  logic [SOURCE_BITS-1:0] d_source,
    input  logic [3:0]             d_size,
    output logic                   a_ok,
    output logic                   d_ok,
    output logic                   stable_ok,
    output logic                   error_sticky,
    output logic [SOURCE_BITS:0]   inflight_cnt
);

    localparam int NSRC  = 1 << SOURCE_BITS;
    // A 4-bit size allows up to 2^15 bytes, i.e. at most 2^15 beats.
    localparam int CNT_W = 16;

    localparam logic [3:0]       LOG2_BEAT = 4'($clog2(BEAT_BYTES));
    localparam logic [3:0]       MAX_SZ    = 4'(MAX_SIZE);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    localparam logic [2:0] OP_PUT_FULL = 3'd0;
    localparam logic [2:0] OP_PUT_PART = 3'd1;
    localparam logic [2:0] OP_GET      = 3'd4;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    // Number of beats a message occupies: one when it carries no data,
    // otherwise the transfer size in bus beats, never less than one.
    function automatic logic [CNT_W-1:0] beats_of(input logic       has_data,
                                                  input logic [3:0] size);
        logic [CNT_W-1:0] n;
        n = CNT_ONE;
        if (has_data && (size > LOG2_BEAT)) begin
            n = CNT_ONE << (size - LOG2_BEAT);
        end
        return n;
    endfunction

    // Control state
    logic [NSRC-1:0]  inflight;
    logic [CNT_W-1:0] a_cnt;
    logic [CNT_W-1:0] d_cnt;
    logic             a_hold_vld_p1;
    logic             d_hold_vld_p1;

    // Per-source expectations recorded at the first A beat
    logic             exp_data [NSRC];
    logic [3:0]       exp_size [NSRC];

    // Fields of the burst in progress on each channel
    logic [SOURCE_BITS-1:0] a_burst_src;
    logic [2:0]             a_burst_op;
    logic [3:0]             a_burst_size;
    logic [CNT_W-1:0]       a_burst_beats;
    logic [SOURCE_BITS-1:0] d_burst_src;
    logic [2:0]             d_burst_op;
    logic [3:0]             d_burst_size;
    logic [CNT_W-1:0]       d_burst_beats;

    // Fields of a stalled beat, compared one cycle later
    logic [2:0]             a_hold_op_p1;
    logic [SOURCE_BITS-1:0] a_hold_src_p1;
    logic [3:0]             a_hold_size_p1;
    logic [2:0]             d_hold_op_p1;
    logic [SOURCE_BITS-1:0] d_hold_src_p1;
    logic [3:0]             d_hold_size_p1;

    // Combinational terms
    logic                   a_fire, d_fire;
    logic                   a_first, d_first;
    logic                   a_has_data;
    logic [CNT_W-1:0]       a_beats_now, d_beats_now;
    logic                   a_first_bad, a_mid_bad;
    logic                   d_first_bad, d_mid_bad;
    logic                   a_accept, d_accept;
    logic                   a_last, d_last;
    logic [SOURCE_BITS-1:0] a_set_src, d_clr_src;
    logic [NSRC-1:0]        set_vec, clr_vec, inflight_eff;
    logic [CNT_W-1:0]       a_cnt_nxt, d_cnt_nxt;
    logic [SOURCE_BITS:0]   inflight_cnt_nxt;
    logic                   a_unstable, d_unstable;

    always_comb begin
        a_fire           = a_valid & a_ready;
        d_fire           = d_valid & d_ready;
        a_first          = (a_cnt == '0);
        d_first          = (d_cnt == '0);
        a_has_data       = (a_opcode == OP_PUT_FULL) || (a_opcode == OP_PUT_PART);
        a_beats_now      = beats_of(a_has_data, a_size);
        d_beats_now      = beats_of(d_opcode == OP_ACK_DATA, d_size);
        d_first_bad      = 1'b0;
        d_mid_bad        = 1'b0;
        a_first_bad      = 1'b0;
        a_mid_bad        = 1'b0;
        d_accept         = 1'b0;
        a_accept         = 1'b0;
        d_last           = 1'b0;
        a_last           = 1'b0;
        d_clr_src        = d_first ? d_source : d_burst_src;
        a_set_src        = a_first ? a_source : a_burst_src;
        clr_vec          = '0;
        set_vec          = '0;
        inflight_eff     = inflight;
        a_cnt_nxt        = a_cnt;
        d_cnt_nxt        = d_cnt;
        inflight_cnt_nxt = inflight_cnt;
        a_ok             = 1'b1;
        d_ok             = 1'b1;
        a_unstable       = 1'b0;
        d_unstable       = 1'b0;
        stable_ok        = 1'b1;

        // D side first: its retire must be visible to the A allocate check
        d_first_bad = !inflight[d_source]
                   || (d_opcode != (exp_data[d_source] ? OP_ACK_DATA : OP_ACK))
                   || (d_size != exp_size[d_source]);
        d_mid_bad   = (d_source != d_burst_src) || (d_opcode != d_burst_op)
                   || (d_size != d_burst_size);
        if (d_fire) begin
            if (d_first) begin
                d_ok     = !d_first_bad;
                d_accept = !d_first_bad;
                // A rejected first beat is dropped without opening a burst
                d_last   = !d_first_bad && (d_beats_now == CNT_ONE);
                if (d_accept && !d_last) begin
                    d_cnt_nxt = CNT_ONE;
                end
            end else begin
                d_ok   = !d_mid_bad;
                d_last = ((d_cnt + CNT_ONE) == d_burst_beats);
                d_cnt_nxt = d_last ? '0 : (d_cnt + CNT_ONE);
            end
        end
        if (d_last) begin
            clr_vec[d_clr_src] = 1'b1;
        end

        // A side sees the inflight vector with this cycle's retire applied
        inflight_eff = inflight & ~clr_vec;
        a_first_bad  = inflight_eff[a_source]
                    || !(a_has_data || (a_opcode == OP_GET))
                    || (a_size > MAX_SZ);
        a_mid_bad    = (a_source != a_burst_src) || (a_opcode != a_burst_op)
                    || (a_size != a_burst_size);
        if (a_fire) begin
            if (a_first) begin
                a_ok     = !a_first_bad;
                a_accept = !a_first_bad;
                a_last   = !a_first_bad && (a_beats_now == CNT_ONE);
                if (a_accept && !a_last) begin
                    a_cnt_nxt = CNT_ONE;
                end
            end else begin
                a_ok   = !a_mid_bad;
                a_last = ((a_cnt + CNT_ONE) == a_burst_beats);
                a_cnt_nxt = a_last ? '0 : (a_cnt + CNT_ONE);
            end
        end
        if (a_last) begin
            set_vec[a_set_src] = 1'b1;
        end

        // A set and a clear in the same cycle cancel in the count, including
        // the bypass case where both name the same source.
        case ({a_last, d_last})
            2'b10:   inflight_cnt_nxt = inflight_cnt + 1'b1;
            2'b01:   inflight_cnt_nxt = inflight_cnt - 1'b1;
            default: inflight_cnt_nxt = inflight_cnt;
        endcase

        // A beat still held valid after a stall must not change its fields
        a_unstable = a_valid && a_hold_vld_p1
                  && ((a_opcode != a_hold_op_p1) || (a_source != a_hold_src_p1)
                      || (a_size != a_hold_size_p1));
        d_unstable = d_valid && d_hold_vld_p1
                  && ((d_opcode != d_hold_op_p1) || (d_source != d_hold_src_p1)
                      || (d_size != d_hold_size_p1));
        stable_ok  = !(a_unstable || d_unstable);
    end

    // Control registers: reset to a clean, nothing-outstanding state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            inflight      <= '0;
            a_cnt         <= '0;
            d_cnt         <= '0;
            inflight_cnt  <= '0;
            error_sticky  <= 1'b0;
            a_hold_vld_p1 <= 1'b0;
            d_hold_vld_p1 <= 1'b0;
        end else begin
            inflight      <= inflight_eff | set_vec;
            a_cnt         <= a_cnt_nxt;
            d_cnt         <= d_cnt_nxt;
            inflight_cnt  <= inflight_cnt_nxt;
            error_sticky  <= error_sticky | ~a_ok | ~d_ok | ~stable_ok;
            a_hold_vld_p1 <= a_valid & ~a_ready;
            d_hold_vld_p1 <= d_valid & ~d_ready;
        end
    end

    // Data registers: only read when qualified by control state above
    always_ff @(posedge clock) begin
        if (a_accept) begin
            a_burst_src          <= a_source;
            a_burst_op           <= a_opcode;
            a_burst_size         <= a_size;
            a_burst_beats        <= a_beats_now;
            exp_data[a_source]   <= (a_opcode == OP_GET);
            exp_size[a_source]   <= a_size;
        end
        if (d_accept) begin
            d_burst_src   <= d_source;
            d_burst_op    <= d_opcode;
            d_burst_size  <= d_size;
            d_burst_beats <= d_beats_now;
        end
        a_hold_op_p1   <= a_opcode;
        a_hold_src_p1  <= a_source;
        a_hold_size_p1 <= a_size;
        d_hold_op_p1   <= d_opcode;
        d_hold_src_p1  <= d_source;
        d_hold_size_p1 <= d_size;
    end

endmodule

// File: tb/tb_tl_inflight_monitor.sv
// Directed bench for tl_inflight_monitor (SOURCE_BITS=4, BEAT_BYTES=8,
// MAX_SIZE=6). Inputs change 1 ns after the rising edge; combinational ok
// terms are sampled on the falling edge, registered outputs 1 ns after the
// following rising edge.
module tb_tl_inflight_monitor;

    localparam int SB = 4;

    logic          clock = 1'b0;
    logic          reset = 1'b1;
    logic          a_valid, a_ready, d_valid, d_ready;
    logic [2:0]    a_opcode, d_opcode;
    logic [SB-1:0] a_source, d_source;
    logic [3:0]    a_size, d_size;
    logic          a_ok, d_ok, stable_ok, error_sticky;
    logic [SB:0]   inflight_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    tl_inflight_monitor #(
        .SOURCE_BITS(SB),
        .BEAT_BYTES (8),
        .MAX_SIZE   (6)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .a_valid     (a_valid),
        .a_ready     (a_ready),
        .a_opcode    (a_opcode),
        .a_source    (a_source),
        .a_size      (a_size),
        .d_valid     (d_valid),
        .d_ready     (d_ready),
        .d_opcode    (d_opcode),
        .d_source    (d_source),
        .d_size      (d_size),
        .a_ok        (a_ok),
        .d_ok        (d_ok),
        .stable_ok   (stable_ok),
        .error_sticky(error_sticky),
        .inflight_cnt(inflight_cnt)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input int obs, input int exp_v);
        n_checks++;
        if (obs != exp_v) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic drv_a(input int v, input int r, input int op, input int src, input int sz);
        a_valid  = 1'(v);
        a_ready  = 1'(r);
        a_opcode = 3'(op);
        a_source = SB'(src);
        a_size   = 4'(sz);
    endtask

    task automatic drv_d(input int v, input int r, input int op, input int src, input int sz);
        d_valid  = 1'(v);
        d_ready  = 1'(r);
        d_opcode = 3'(op);
        d_source = SB'(src);
        d_size   = 4'(sz);
    endtask

    task automatic idle_a();
        drv_a(0, 0, 0, 0, 0);
    endtask

    task automatic idle_d();
        drv_d(0, 0, 0, 0, 0);
    endtask

    task automatic mid_cycle();
        @(negedge clock);
    endtask

    task automatic next_cycle();
        @(posedge clock);
        #1;
    endtask

    task automatic chk_ok(input string tag, input int ea, input int ed, input int es);
        check({tag, ".a_ok"}, int'(a_ok), ea);
        check({tag, ".d_ok"}, int'(d_ok), ed);
        check({tag, ".stable_ok"}, int'(stable_ok), es);
    endtask

    task automatic chk_st(input string tag, input int ecnt, input int esticky);
        check({tag, ".cnt"}, int'(inflight_cnt), ecnt);
        check({tag, ".sticky"}, int'(error_sticky), esticky);
    endtask

    task automatic do_reset(input string tag);
        idle_a();
        idle_d();
        reset = 1'b1;
        #1;
        chk_ok(tag, 1, 1, 1);
        chk_st(tag, 0, 0);
        next_cycle();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        idle_a();
        idle_d();
        repeat (2) @(posedge clock);
        #1;
        chk_ok("reset", 1, 1, 1);
        chk_st("reset", 0, 0);
        reset = 1'b0;

        // 1: Get src 3 size 6 answered by 8 AccessAckData beats
        drv_a(1, 1, 4, 3, 6);
        mid_cycle();
        chk_ok("t1_get", 1, 1, 1);
        next_cycle();
        chk_st("t1_get", 1, 0);
        idle_a();
        for (int i = 0; i < 8; i++) begin
            drv_d(1, 1, 1, 3, 6);
            mid_cycle();
            check($sformatf("t1_d%0d.d_ok", i), int'(d_ok), 1);
            next_cycle();
            check($sformatf("t1_d%0d.cnt", i), int'(inflight_cnt), (i < 7) ? 1 : 0);
        end
        idle_d();
        chk_st("t1_end", 0, 0);

        // 2: duplicate source, illegal opcode/size, mid-burst A change
        drv_a(1, 1, 0, 2, 3);
        mid_cycle();
        chk_ok("t2_put", 1, 1, 1);
        next_cycle();
        chk_st("t2_put", 1, 0);
        drv_a(1, 1, 0, 2, 3);
        mid_cycle();
        chk_ok("t2_dup", 0, 1, 1);
        next_cycle();
        chk_st("t2_dup", 1, 1);
        idle_a();
        drv_d(1, 1, 0, 2, 3);
        mid_cycle();
        chk_ok("t2_ack", 1, 1, 1);
        next_cycle();
        chk_st("t2_ack", 0, 1);
        idle_d();
        drv_a(1, 1, 2, 8, 3);
        mid_cycle();
        check("t2_badop.a_ok", int'(a_ok), 0);
        next_cycle();
        drv_a(1, 1, 4, 9, 7);
        mid_cycle();
        check("t2_size7.a_ok", int'(a_ok), 0);
        next_cycle();
        check("t2_size7.cnt", int'(inflight_cnt), 0);
        drv_a(1, 1, 4, 9, 6);
        mid_cycle();
        check("t2_size6.a_ok", int'(a_ok), 1);
        next_cycle();
        check("t2_size6.cnt", int'(inflight_cnt), 1);
        drv_a(1, 1, 0, 10, 4);
        mid_cycle();
        check("t2_burst0.a_ok", int'(a_ok), 1);
        next_cycle();
        check("t2_burst0.cnt", int'(inflight_cnt), 1);
        drv_a(1, 1, 0, 10, 5);
        mid_cycle();
        check("t2_burst1.a_ok", int'(a_ok), 0);
        next_cycle();
        check("t2_burst1.cnt", int'(inflight_cnt), 2);

        do_reset("t3_rst");

        // 3: unknown source, then opcode and size mismatch on src 1
        drv_d(1, 1, 1, 5, 3);
        mid_cycle();
        chk_ok("t3_unk", 1, 0, 1);
        next_cycle();
        chk_st("t3_unk", 0, 1);
        idle_d();
        drv_a(1, 1, 4, 1, 2);
        mid_cycle();
        chk_ok("t3_get", 1, 1, 1);
        next_cycle();
        chk_st("t3_get", 1, 1);
        idle_a();
        drv_d(1, 1, 0, 1, 2);
        mid_cycle();
        chk_ok("t3_opmis", 1, 0, 1);
        next_cycle();
        check("t3_opmis.cnt", int'(inflight_cnt), 1);
        drv_d(1, 1, 1, 1, 3);
        mid_cycle();
        check("t3_szmis.d_ok", int'(d_ok), 0);
        next_cycle();
        drv_d(1, 1, 1, 1, 2);
        mid_cycle();
        check("t3_good.d_ok", int'(d_ok), 1);
        next_cycle();
        check("t3_good.cnt", int'(inflight_cnt), 0);

        do_reset("t4_rst");

        // 4: stalled A changes source in its 2nd stall cycle; D stall checks
        drv_a(1, 0, 4, 4, 3);
        mid_cycle();
        chk_ok("t4_s1", 1, 1, 1);
        next_cycle();
        drv_a(1, 0, 4, 6, 3);
        mid_cycle();
        chk_ok("t4_s2", 1, 1, 0);
        next_cycle();
        chk_st("t4_s2", 0, 1);
        drv_a(1, 0, 4, 6, 3);
        mid_cycle();
        chk_ok("t4_s3", 1, 1, 1);
        next_cycle();
        drv_a(1, 1, 4, 6, 3);
        mid_cycle();
        chk_ok("t4_fire", 1, 1, 1);
        next_cycle();
        check("t4_fire.cnt", int'(inflight_cnt), 1);
        idle_a();
        drv_d(1, 0, 1, 6, 3);
        mid_cycle();
        chk_ok("t4_d1", 1, 1, 1);
        next_cycle();
        drv_d(1, 0, 1, 6, 2);
        mid_cycle();
        chk_ok("t4_d2", 1, 1, 0);
        next_cycle();
        idle_d();
        next_cycle();
        drv_d(1, 1, 1, 6, 3);
        mid_cycle();
        chk_ok("t4_dfire", 1, 1, 1);
        next_cycle();
        check("t4_dfire.cnt", int'(inflight_cnt), 0);
        idle_d();

        do_reset("t5_rst");

        // 5: last D beat of src 7 and a new Get on src 7 in the same cycle
        drv_a(1, 1, 4, 7, 4);
        mid_cycle();
        chk_ok("t5_get1", 1, 1, 1);
        next_cycle();
        idle_a();
        drv_d(1, 1, 1, 7, 4);
        mid_cycle();
        chk_ok("t5_d0", 1, 1, 1);
        next_cycle();
        check("t5_d0.cnt", int'(inflight_cnt), 1);
        drv_a(1, 1, 4, 7, 3);
        drv_d(1, 1, 1, 7, 4);
        mid_cycle();
        chk_ok("t5_bypass", 1, 1, 1);
        next_cycle();
        chk_st("t5_bypass", 1, 0);
        idle_a();
        drv_d(1, 1, 1, 7, 3);
        mid_cycle();
        check("t5_resp2.d_ok", int'(d_ok), 1);
        next_cycle();
        chk_st("t5_resp2", 0, 0);
        idle_d();

        // 6: reset during beat 4 of an 8-beat D burst
        drv_a(1, 1, 4, 3, 6);
        next_cycle();
        idle_a();
        for (int i = 0; i < 3; i++) begin
            drv_d(1, 1, 1, 3, 6);
            mid_cycle();
            check($sformatf("t6_d%0d.d_ok", i), int'(d_ok), 1);
            next_cycle();
        end
        drv_d(1, 1, 1, 3, 6);
        #1;
        do_reset("t6_rst");
        for (int i = 4; i < 8; i++) begin
            drv_d(1, 1, 1, 3, 6);
            mid_cycle();
            check($sformatf("t6_post%0d.d_ok", i), int'(d_ok), 0);
            next_cycle();
            check($sformatf("t6_post%0d.cnt", i), int'(inflight_cnt), 0);
        end
        idle_d();
        check("t6_end.sticky", int'(error_sticky), 1);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
